// File: rtl/cpc_bus_pkg.sv
// ============================================================================
// Module : cpc_bus_pkg
// Brief  : Shared constants and types for the CPC Z80 bus decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpc_bus_pkg;

    // Gate Array function codes carried in dout[7:6]
    localparam logic [1:0] GA_FN_ROM = 2'b10;
    localparam logic [1:0] GA_FN_RAM = 2'b11;

    // Port-select address bits (active low except GA A14, which must be 1)
    localparam int GA_BIT     = 14;
    localparam int ROMSEL_BIT = 13;
    localparam int PIO_BIT    = 11;

    typedef enum logic [1:0] {
        REGION_LROM = 2'b00,
        REGION_RAM1 = 2'b01,
        REGION_RAM2 = 2'b10,
        REGION_UROM = 2'b11
    } region_e;

    typedef struct packed {
        logic l_rom;
        logic u_rom;
        logic ram;
        logic io;
        logic pio;
    } src_sel_t;

endpackage

`default_nettype wire

// File: rtl/cpc_bus_decode_if.sv
// ============================================================================
// Module : cpc_bus_decode_if
// Brief  : CPU bus strobes in, data-source enables / config / wait out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpc_bus_decode_if;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        l_rom_e;
    logic        u_rom_e;
    logic        ram_e;
    logic        io_e;
    logic        pio8255_e;
    logic [7:0]  urom_sel;
    logic [2:0]  ram_cfg;
    logic        wait_n;

    modport master (
        output A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n,
        input  l_rom_e, u_rom_e, ram_e, io_e, pio8255_e, urom_sel, ram_cfg, wait_n
    );

    modport slave (
        input  A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n,
        output l_rom_e, u_rom_e, ram_e, io_e, pio8255_e, urom_sel, ram_cfg, wait_n
    );
endinterface

`default_nettype wire

// File: rtl/cpc_wait_gen.sv
// ============================================================================
// Module : cpc_wait_gen
// Brief  : Holds wait_n low for WAIT_CYCLES clocks after each mem-read start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpc_wait_gen #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic mem_rd_i,
    output logic      wait_n_o
);

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

    logic       mem_rd_prev_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A fresh read start always reloads, even mid-count; a dropped read never aborts.
    always_comb begin
        cnt_d = cnt_q;
        if (mem_rd_i && !mem_rd_prev_q) begin
            cnt_d = c_wait_load;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd_prev_q <= 1'b0;
            cnt_q         <= 4'd0;
        end else begin
            mem_rd_prev_q <= mem_rd_i;
            cnt_q         <= cnt_d;
        end
    end

    assign wait_n_o = (cnt_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/cpc_bus_decode.sv
// ============================================================================
// Module : cpc_bus_decode
// Brief  : Z80 bus decoder, Gate Array / ROM-select config, wait insertion.
//          Optional RAM banking register enabled by CPC_RAM_BANK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpc_bus_decode
    import cpc_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpc_bus_decode_if.slave   bus
);

    logic     w_mem_rd;
    logic     w_io_rd;
    logic     w_io_wr;
    logic     w_ga_hit;
    logic     w_romsel_hit;
    region_e  w_region;
    logic     w_unused_addr;

    src_sel_t sel_d;
    src_sel_t sel_q;
    logic     lrom_dis_d;
    logic     lrom_dis_q;
    logic     urom_dis_d;
    logic     urom_dis_q;
    logic [7:0] urom_sel_d;
    logic [7:0] urom_sel_q;

    assign w_mem_rd     = !bus.mreq_n && !bus.rd_n;
    assign w_io_rd      = !bus.iorq_n && !bus.rd_n && bus.m1_n;
    assign w_io_wr      = !bus.iorq_n && !bus.wr_n;
    assign w_ga_hit     = !bus.A[15] && bus.A[GA_BIT];
    assign w_romsel_hit = !bus.A[ROMSEL_BIT];
    assign w_region     = region_e'(bus.A[15:14]);
    assign w_unused_addr = ^{bus.A[12], bus.A[10:0]};

    // Source select: memory reads take priority, interrupt ack is excluded by io_rd.
    always_comb begin
        sel_d = '0;
        if (w_mem_rd) begin
            if (w_region == REGION_LROM && !lrom_dis_q) begin
                sel_d.l_rom = 1'b1;
            end else if (w_region == REGION_UROM && !urom_dis_q) begin
                sel_d.u_rom = 1'b1;
            end else begin
                sel_d.ram = 1'b1;
            end
        end else if (w_io_rd) begin
            if (!bus.A[PIO_BIT]) begin
                sel_d.pio = 1'b1;
            end else begin
                sel_d.io = 1'b1;
            end
        end
    end

    // A single write may address both the Gate Array and ROM select ports.
    always_comb begin
        lrom_dis_d = lrom_dis_q;
        urom_dis_d = urom_dis_q;
        urom_sel_d = urom_sel_q;
        if (w_io_wr) begin
            if (w_ga_hit && bus.dout[7:6] == GA_FN_ROM) begin
                lrom_dis_d = bus.dout[2];
                urom_dis_d = bus.dout[3];
            end
            if (w_romsel_hit) begin
                urom_sel_d = bus.dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= '0;
            lrom_dis_q <= 1'b0;
            urom_dis_q <= 1'b0;
            urom_sel_q <= 8'h00;
        end else begin
            sel_q      <= sel_d;
            lrom_dis_q <= lrom_dis_d;
            urom_dis_q <= urom_dis_d;
            urom_sel_q <= urom_sel_d;
        end
    end

`ifdef CPC_RAM_BANK_EN
    logic [2:0] ram_cfg_d;
    logic [2:0] ram_cfg_q;

    always_comb begin
        ram_cfg_d = ram_cfg_q;
        if (w_io_wr && w_ga_hit && bus.dout[7:6] == GA_FN_RAM) begin
            ram_cfg_d = bus.dout[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_cfg_q <= 3'd0;
        end else begin
            ram_cfg_q <= ram_cfg_d;
        end
    end

    assign bus.ram_cfg = ram_cfg_q;
`else
    assign bus.ram_cfg = 3'd0;
`endif

    assign bus.l_rom_e   = sel_q.l_rom;
    assign bus.u_rom_e   = sel_q.u_rom;
    assign bus.ram_e     = sel_q.ram;
    assign bus.io_e      = sel_q.io;
    assign bus.pio8255_e = sel_q.pio;
    assign bus.urom_sel  = urom_sel_q;

    cpc_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gen (
        .clk      (clk),
        .reset    (reset),
        .mem_rd_i (w_mem_rd),
        .wait_n_o (bus.wait_n)
    );

endmodule

`default_nettype wire

// File: tb/tb_cpc_bus_decode.sv
// ============================================================================
// Module : tb_cpc_bus_decode
// Brief  : Directed self-checking bench for cpc_bus_decode (WAIT=2 and WAIT=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpc_bus_decode;

    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_L    = 5'b10000;
    localparam logic [4:0] EN_U    = 5'b01000;
    localparam logic [4:0] EN_RAM  = 5'b00100;
    localparam logic [4:0] EN_IO   = 5'b00010;
    localparam logic [4:0] EN_PIO  = 5'b00001;

`ifdef CPC_RAM_BANK_EN
    localparam logic [2:0] EXP_RAM_CFG = 3'd5;
`else
    localparam logic [2:0] EXP_RAM_CFG = 3'd0;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    cpc_bus_decode_if bus ();
    cpc_bus_decode_if bus0 ();

    assign bus0.A      = bus.A;
    assign bus0.dout   = bus.dout;
    assign bus0.mreq_n = bus.mreq_n;
    assign bus0.iorq_n = bus.iorq_n;
    assign bus0.rd_n   = bus.rd_n;
    assign bus0.wr_n   = bus.wr_n;
    assign bus0.m1_n   = bus.m1_n;

    cpc_bus_decode #(.WAIT_CYCLES(2)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    cpc_bus_decode #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] en();
        return {bus.l_rom_e, bus.u_rom_e, bus.ram_e, bus.io_e, bus.pio8255_e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.m1_n   = 1'b1;
    endtask

    task automatic mem_read(input string tag, input logic [15:0] a, input logic [4:0] exp_en);
        int low  = 0;
        int low0 = 0;
        @(negedge clk);
        bus.A = a; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk({tag, "_en"}, 32'(en()), 32'(exp_en));
            if (!bus.wait_n)  low++;
            if (!bus0.wait_n) low0++;
        end
        @(negedge clk);
        bus_idle();
        @(posedge clk); #1;
        chk({tag, "_rel"}, 32'(en()), 32'(EN_NONE));
        chk({tag, "_wait2"}, 32'(low), 32'd2);
        chk({tag, "_wait0"}, 32'(low0), 32'd0);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.A = a; bus.dout = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus_idle();
        #6;
    endtask

    task automatic io_read(input string tag, input logic [15:0] a, input logic m1, input logic [4:0] exp_en);
        @(negedge clk);
        bus.A = a; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.m1_n = m1;
        @(posedge clk); #1;
        chk(tag, 32'(en()), 32'(exp_en));
        @(negedge clk);
        bus_idle();
        @(posedge clk); #1;
        chk({tag, "_rel"}, 32'(en()), 32'(EN_NONE));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.A    = 16'h0000;
        bus.dout = 8'h00;
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en",      32'(en()), 32'(EN_NONE));
        chk("rst_wait_n",  32'(bus.wait_n), 32'd1);
        chk("rst_urom",    32'(bus.urom_sel), 32'h00);
        chk("rst_ram_cfg", 32'(bus.ram_cfg), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        mem_read("rd_lrom", 16'h0010, EN_L);
        mem_read("rd_urom", 16'hC000, EN_U);
        mem_read("rd_ram",  16'h4000, EN_RAM);

        // Both ROMs disabled: every read falls through to RAM.
        io_write(16'h7F00, 8'h8C);
        mem_read("dis_lrom", 16'h0010, EN_RAM);
        mem_read("dis_urom", 16'hC000, EN_RAM);
        io_write(16'h7F00, 8'h80);
        mem_read("ena_lrom", 16'h0010, EN_L);
        mem_read("ena_urom", 16'hC000, EN_U);

        io_write(16'hDF00, 8'h07);
        chk("urom_sel_07", 32'(bus.urom_sel), 32'h07);
        io_write(16'h5F00, 8'h84);
        chk("urom_sel_84", 32'(bus.urom_sel), 32'h84);
        mem_read("dual_lrom", 16'h0010, EN_RAM);
        mem_read("dual_urom", 16'hC000, EN_U);

        io_read("io_pio",  16'hF400, 1'b1, EN_PIO);
        io_read("io_gen",  16'hFB7E, 1'b1, EN_IO);
        io_read("int_ack", 16'hF400, 1'b0, EN_NONE);

        io_write(16'h7F00, 8'hC5);
        chk("ram_cfg", 32'(bus.ram_cfg), 32'(EXP_RAM_CFG));
        chk("ram_fn_keeps_urom", 32'(bus.urom_sel), 32'h84);
        mem_read("ram_fn_lrom", 16'h0010, EN_RAM);

        // Reset one clock into a wait aborts it and clears all config.
        @(negedge clk);
        bus.A = 16'h4000; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_wait", 32'(bus.wait_n), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_wait",  32'(bus.wait_n), 32'd1);
        chk("mid_rst_en",    32'(en()), 32'(EN_NONE));
        chk("mid_rst_urom",  32'(bus.urom_sel), 32'h00);
        chk("mid_rst_ramcfg", 32'(bus.ram_cfg), 32'd0);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        mem_read("post_rst_lrom", 16'h0010, EN_L);
        mem_read("post_rst_urom", 16'hC000, EN_U);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpc_bus_decode.md
# cpc_bus_decode

Z80 bus decoder and memory-configuration register file for the CPC core. It samples the CPU control strobes and address each clock and holds the Gate Array ROM-enable bits, the upper-ROM select and the RAM configuration. It produces the registered source-select enables consumed by the CPU data-in multiplexer (`l_rom_e`, `u_rom_e`, `ram_e`, `io_e`, `pio8255_e`). It also stretches memory reads with a programmable `wait_n` pulse so slow ROM/RAM back-ends have time to respond.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: clocks `wait_n` is held low per memory read; range 0–15; 0 disables wait insertion.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `A`  in  16  CPU address bus
- `dout`  in  8  CPU write data
- `mreq_n`  in  1  memory request, active low
- `iorq_n`  in  1  I/O request, active low
- `rd_n`  in  1  read strobe, active low
- `wr_n`  in  1  write strobe, active low
- `m1_n`  in  1  opcode fetch / interrupt ack, active low
- `l_rom_e`  out  1  lower ROM drives CPU data
- `u_rom_e`  out  1  upper ROM drives CPU data
- `ram_e`  out  1  RAM drives CPU data
- `io_e`  out  1  generic I/O drives CPU data
- `pio8255_e`  out  1  8255 drives CPU data
- `urom_sel`  out  8  selected upper ROM number
- `ram_cfg`  out  3  RAM banking configuration
- `wait_n`  out  1  CPU wait request, active low

## Operation
- Cycle qualifiers, decoded from inputs:
  - `mem_rd` = !mreq_n & !rd_n
  - `io_rd` = !iorq_n & !rd_n & m1_n
  - `io_wr` = !iorq_n & !wr_n
- Config registers update on an `io_wr` clock edge:
  - Gate Array port (A15=0, A14=1):
    - dout[7:6]=10: `lrom_dis` <= dout[2], `urom_dis` <= dout[3].
    - dout[7:6]=11: `ram_cfg` <= dout[2:0].
    - Other function codes are ignored.
  - ROM select (A13=0): `urom_sel` <= dout.
  - One write may hit both ports (e.g. A=0x5F00); both update in the same edge.
  - A held write strobe rewrites the same value each clock. This is harmless.
- Enables are registered and mutually exclusive. Each edge computes:
  - `mem_rd`, A[15:14]=00, !`lrom_dis` -> `l_rom_e`
  - `mem_rd`, A[15:14]=11, !`urom_dis` -> `u_rom_e`
  - other `mem_rd` -> `ram_e`
  - `io_rd`, A11=0 -> `pio8255_e`
  - other `io_rd` -> `io_e`
  - otherwise all enables 0
- Interrupt acknowledge (m1_n & iorq_n both low) asserts no enable.
- Wait generator:
  - Idle: rising edge of `mem_rd` (registered previous value was 0) loads counter with WAIT_CYCLES.
  - Count: `wait_n`=0 while counter != 0; decrements each clock.
  - A new `mem_rd` edge during Count is impossible on a legal Z80 bus. If one occurs anyway, the counter reloads.
  - `mem_rd` dropping during Count does not abort the count.

## Timing
- Reset values:
  - all enables 0
  - `lrom_dis`=0, `urom_dis`=0 (both ROMs visible)
  - `urom_sel`=0x00, `ram_cfg`=0
  - `wait_n`=1, counter 0, previous-`mem_rd` 0
- Enable latency is 1 clock: bus state at edge N drives the enables after edge N. Enables drop 1 clock after the strobe releases.
- Config latency: registers update at the write edge. A read in the next cycle uses the new mapping.
- Wait latency:
  - `wait_n` falls 1 clock after the `mem_rd` rising edge is sampled.
  - It stays low exactly WAIT_CYCLES clocks.
- Reset asserted mid-cycle: at that edge all outputs return to reset values, any wait is aborted and config is lost.
- Bus inputs must be synchronous to `clk`. No synchronisers are included.

## Configuration
- `CPC_RAM_BANK_EN`:
  - Defined: the `ram_cfg` register is implemented as above.
  - Undefined: `ram_cfg` is constant 0 and dout[7:6]=11 writes are ignored.
  - ROM enables, `urom_sel` and wait behaviour are identical in both builds.

## Structure
- Shared package `cpc_bus_pkg`:
  - Gate Array function codes (`GA_FN_ROM`=2'b10, `GA_FN_RAM`=2'b11)
  - port address bit positions (GA A14, ROMSEL A13, PIO A11)
  - region codes for A[15:14]
- One sub-module, `cpc_wait_gen`: edge detect, counter and `wait_n`, parameterised by WAIT_CYCLES.

## Test plan
- Reset, then mem read A=0x0010 -> `l_rom_e`=1 one clock later; A=0xC000 -> `u_rom_e`=1; A=0x4000 -> `ram_e`=1; `wait_n`=0 for exactly 2 clocks on each.
- IO write A=0x7F00 dout=0x8C, then reads at 0x0010 and 0xC000 -> `ram_e`=1 for both. Write dout=0x80 -> ROM enables restored.
- IO write A=0xDF00 dout=0x07 -> `urom_sel`=0x07. Write A=0x5F00 dout=0x84 -> `lrom_dis`=1 and `urom_sel`=0x84 in the same edge.
- IO read A=0xF400 -> `pio8255_e`=1; A=0xFB7E -> `io_e`=1; m1_n=0 with iorq_n=0 -> all enables 0.
- With `CPC_RAM_BANK_EN`: IO write 0x7F00/0xC5 -> `ram_cfg`=5. Without the macro -> `ram_cfg` stays 0.
- Reset asserted 1 clock into a wait -> `wait_n`=1, enables 0, config at reset values at the next edge. WAIT_CYCLES=0 -> `wait_n` never low.
